// File: rtl/life_seed_loader.sv
// -----------------------------------------------------------------------------
// life_seed_loader
//
// Streams a NUM_COLS-nibble seed pattern into a Game-of-Life column scan chain.
// Once the seed is loaded, it paces generation-advance pulses at one every
// GEN_PERIOD clocks while `run` is high.
//
// Optional feature: define LIFE_LOADER_STEP_EN to let a `step` pulse issued
// while paused (HOLD, seed loaded) advance exactly one generation. When the
// macro is undefined, `step` is accepted on the port and ignored.
//
// Parameters
//   NUM_COLS    number of 4-cell columns in the chain (1..255)
//   GEN_PERIOD  clocks per generation while running (2..2^26-1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   seed_valid  upstream nibble available
//   seed_data   column pattern, bit 0 = top cell (row 0)
//   seed_ready  loader accepts a nibble this cycle (LOAD state only)
//   start       pulse: begin or restart a seed load from any state
//   run         level: evolve generations while high
//   step        pulse: single generation while paused (LIFE_LOADER_STEP_EN)
//   scan        one-cycle pulse per accepted nibble, one cycle after the transfer
//   scan_val    nibble shifted into the chain; holds its last value otherwise
//   enable      one-cycle generation-advance pulse to all columns
//   loaded      full seed loaded and not restarted since
//   gen_count   generations advanced since the last load (wraps at 16 bits)
// -----------------------------------------------------------------------------
module life_seed_loader #(
    parameter int unsigned NUM_COLS   = 8,
    parameter int unsigned GEN_PERIOD = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        seed_valid,
    input  logic [3:0]  seed_data,
    output logic        seed_ready,
    input  logic        start,
    input  logic        run,
    input  logic        step,
    output logic        scan,
    output logic [3:0]  scan_val,
    output logic        enable,
    output logic        loaded,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    localparam logic [7:0]  LAST_COL  = 8'(NUM_COLS - 1);
    localparam logic [25:0] TICK_LAST = 26'(GEN_PERIOD - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  col_cnt;
    logic [25:0] tick;
    logic        xfer;
    logic        last_xfer;
    logic        gen_due;
    logic        step_fire;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples pre-edge values, whatever order the
    // simulator evaluates the blocks in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic; start overrides everything else
    // -------------------------------------------------------------------------
    // NOTE: each combinational output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = LOAD;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                LOAD:    if (last_xfer) state_next = HOLD;
                HOLD:    if (run)       state_next = RUN;
                RUN:     if (!run)      state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        seed_ready = (state == LOAD);
        // A handshake landing on a start pulse is discarded.
        xfer       = seed_valid && seed_ready && !start;
        last_xfer  = xfer && (col_cnt == LAST_COL);
        // Requiring run here drops a due pulse when run falls on that cycle.
        gen_due    = (state == RUN) && run && !start && (tick == TICK_LAST);
    end

`ifdef LIFE_LOADER_STEP_EN
    assign step_fire = (state == HOLD) && loaded && step && !start;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_fire   = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Registered datapath: column counter, generation timer, output pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt   <= '0;
            tick      <= '0;
            scan      <= 1'b0;
            scan_val  <= '0;
            enable    <= 1'b0;
            loaded    <= 1'b0;
            gen_count <= '0;
        end else begin
            // scan comes only from LOAD, enable only from HOLD/RUN, so the two
            // pulses can never coincide.
            scan   <= xfer;
            enable <= gen_due || step_fire;
            if (xfer) begin
                scan_val <= seed_data;
            end

            if (start) begin
                col_cnt   <= '0;
                tick      <= '0;
                loaded    <= 1'b0;
                gen_count <= '0;
            end else begin
                if (xfer) begin
                    col_cnt <= last_xfer ? 8'd0 : col_cnt + 8'd1;
                end
                if (last_xfer) begin
                    loaded <= 1'b1;
                end
                if (gen_due || step_fire) begin
                    gen_count <= gen_count + 16'd1;
                end

                // The HOLD->RUN transition cycle counts as tick 0, so the first
                // RUN cycle already holds 1 and the first enable lands exactly
                // GEN_PERIOD cycles after the transition.
                case (state)
                    HOLD:    tick <= run ? 26'd1 : 26'd0;
                    RUN:     tick <= (!run || tick == TICK_LAST) ? 26'd0 : tick + 26'd1;
                    default: tick <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_seed_loader.sv
// -----------------------------------------------------------------------------
// tb_life_seed_loader
//
// Directed bench for life_seed_loader with NUM_COLS=4, GEN_PERIOD=4. Nibbles
// accepted by the loader are pushed to a scoreboard queue when driven and
// popped when the matching scan pulse appears. Inputs change 1 ns after each
// rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_life_seed_loader;

    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned GEN_PERIOD = 4;
`ifdef LIFE_LOADER_STEP_EN
    localparam logic STEP_EXP = 1'b1;
`else
    localparam logic STEP_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_valid;
    logic [3:0]  seed_data;
    logic        seed_ready;
    logic        start;
    logic        run;
    logic        step;
    logic        scan;
    logic [3:0]  scan_val;
    logic        enable;
    logic        loaded;
    logic [15:0] gen_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [3:0] exp_q[$];

    life_seed_loader #(
        .NUM_COLS   (NUM_COLS),
        .GEN_PERIOD (GEN_PERIOD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .seed_ready (seed_ready),
        .start      (start),
        .run        (run),
        .step       (step),
        .scan       (scan),
        .scan_val   (scan_val),
        .enable     (enable),
        .loaded     (loaded),
        .gen_count  (gen_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; exp_xfer says whether the inputs held over that edge
    // should have produced a transfer (and hence a scan pulse now).
    task automatic cyc(input logic exp_xfer);
        @(posedge clk);
        #1;
        check("scan", scan, exp_xfer);
        check("scan_enable_excl", scan & enable, 0);
        if (scan === 1'b1 && exp_q.size() > 0) begin
            check("scan_val", scan_val, exp_q.pop_front());
        end
    endtask

    // Present one nibble in LOAD; the scoreboard expects it on scan next cycle.
    task automatic send(input logic [3:0] d);
        seed_valid = 1'b1;
        seed_data  = d;
        exp_q.push_back(d);
        cyc(1'b1);
        seed_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        seed_valid = 1'b0;
        seed_data  = 4'h0;
        start      = 1'b0;
        run        = 1'b0;
        step       = 1'b0;

        // ---- reset held two cycles ------------------------------------------
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_seed_ready", seed_ready, 0);
        check("rst_scan_val", scan_val, 0);
        check("rst_enable", enable, 0);
        check("rst_loaded", loaded, 0);
        check("rst_gen_count", gen_count, 0);
        // IDLE ignores seed_valid
        seed_valid = 1'b1;
        seed_data  = 4'hA;
        cyc(1'b0);
        check("idle_seed_ready", seed_ready, 0);
        seed_valid = 1'b0;

        // ---- first load: 1,8,6,F -------------------------------------------
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
        check("load_seed_ready", seed_ready, 1);
        send(4'h1);
        send(4'h8);
        send(4'h6);
        check("load_not_done", loaded, 0);
        send(4'hF);
        check("load_done", loaded, 1);
        check("load_ready_low", seed_ready, 0);
        // HOLD ignores seed_valid
        seed_valid = 1'b1;
        seed_data  = 4'h7;
        cyc(1'b0);
        seed_valid = 1'b0;
        check("hold_enable", enable, 0);

        // ---- run for 20 cycles: enable at 4,8,12,16,20 ---------------------
        run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0);
            check($sformatf("run_enable_%0d", i), enable, (i % 4 == 0) ? 1 : 0);
            check($sformatf("run_gen_%0d", i), gen_count, i / 4);
        end
        run = 1'b0;
        cyc(1'b0);
        check("stop_enable", enable, 0);
        check("stop_gen", gen_count, 5);

        // ---- run dropped one cycle before a due enable ---------------------
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0);
            check($sformatf("drop_pre_enable_%0d", i), enable, 0);
        end
        run = 1'b0;
        cyc(1'b0);
        check("drop_enable", enable, 0);
        check("drop_gen", gen_count, 5);
        cyc(1'b0);
        check("drop_hold_enable", enable, 0);

        // ---- step while paused ---------------------------------------------
        step = 1'b1;
        cyc(1'b0);
        step = 1'b0;
        check("step_enable", enable, STEP_EXP);
        check("step_gen", gen_count, 5 + STEP_EXP);
        cyc(1'b0);
        check("step_single", enable, 0);

        // ---- restart mid-load ----------------------------------------------
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
        check("restart_loaded", loaded, 0);
        check("restart_gen", gen_count, 0);
        send(4'hC);
        send(4'h5);
        // start coincides with a valid nibble: that nibble is discarded
        start      = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 4'h9;
        cyc(1'b0);
        start      = 1'b0;
        seed_valid = 1'b0;
        check("restart2_ready", seed_ready, 1);
        send(4'h3);
        send(4'h3);
        check("restart2_not_done_2", loaded, 0);
        send(4'h0);
        check("restart2_not_done_3", loaded, 0);
        send(4'h0);
        check("restart2_done", loaded, 1);
        check("restart2_ready_low", seed_ready, 0);

        // ---- reset mid-load abandons it ------------------------------------
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
        reset      = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 4'h7;
        cyc(1'b0);
        reset = 1'b0;
        check("mid_rst_ready", seed_ready, 0);
        check("mid_rst_scan_val", scan_val, 0);
        check("mid_rst_loaded", loaded, 0);
        cyc(1'b0);
        seed_valid = 1'b0;
        check("mid_rst_idle_ready", seed_ready, 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
